// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream reset domains, then releases them one by
// one after a programmable delay, optionally waiting for a per-stage acknowledge.
module rst_seq_ctrl #(
    parameter int unsigned G_NUM_STAGES  = 4,
    parameter int unsigned G_HOLD_CYCLES = 16,
    parameter int unsigned G_STAGE_DELAY = 8,
    parameter int unsigned G_ACK_TIMEOUT = 1024,
    parameter int unsigned G_CNT_WIDTH   = 16
) (
    input  logic                    clk_sys_i,
    input  logic                    sys_rst_i,
    input  logic                    sw_rst_req_i,
    input  logic [G_NUM_STAGES-1:0] stage_ack_i,
    input  logic [G_NUM_STAGES-1:0] stage_ack_en_i,
    output logic [G_NUM_STAGES-1:0] stage_rstn_o,
    output logic                    seq_busy_o,
    output logic                    seq_done_o,
    output logic                    fault_o,
    output logic [3:0]              fault_stage_o
);

    localparam longint unsigned C_CNT_LIMIT = (64'd1 << G_CNT_WIDTH) - 64'd1;

    if (G_NUM_STAGES < 1 || G_NUM_STAGES > 16) begin : g_bad_stages
        $error("rst_seq_ctrl: G_NUM_STAGES must be 1..16");
    end
    if (64'(G_HOLD_CYCLES) > C_CNT_LIMIT || 64'(G_STAGE_DELAY) > C_CNT_LIMIT ||
        64'(G_ACK_TIMEOUT) > C_CNT_LIMIT) begin : g_bad_cnt
        $error("rst_seq_ctrl: a cycle count exceeds the counter range");
    end

    localparam logic [G_CNT_WIDTH-1:0] C_HOLD_LAST  = G_CNT_WIDTH'(G_HOLD_CYCLES - 1);
    localparam logic [G_CNT_WIDTH-1:0] C_DELAY_LAST = G_CNT_WIDTH'(G_STAGE_DELAY - 1);
    localparam logic [G_CNT_WIDTH-1:0] C_TO_LAST    = G_CNT_WIDTH'(G_ACK_TIMEOUT - 1);
    localparam logic [3:0]             C_LAST_IDX   = 4'(G_NUM_STAGES - 1);

    typedef enum logic [2:0] {S_HOLD, S_DELAY, S_WAIT_ACK, S_DONE, S_FAULT} state_t;

    state_t                  r_state,  w_nxt_state;
    logic [G_CNT_WIDTH-1:0]  r_cnt,    w_nxt_cnt, w_cnt_inc;
    logic [3:0]              r_idx,    w_nxt_idx;
    logic [G_NUM_STAGES-1:0] r_rstn,   w_nxt_rstn;
    logic                    r_busy,   w_nxt_busy;
    logic                    r_done,   w_nxt_done;
    logic                    r_fault,  w_nxt_fault;
    logic [3:0]              r_fstage, w_nxt_fstage;
    logic                    w_ack_cur, w_en_cur, w_advance;
    logic [G_NUM_STAGES-1:0] w_idx_mask;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + G_CNT_WIDTH'(1);

    always_comb begin
        w_ack_cur  = 1'b0;
        w_en_cur   = 1'b0;
        w_idx_mask = '0;
        for (int unsigned k = 0; k < G_NUM_STAGES; k++) begin
            if (4'(k) == r_idx) begin
                w_ack_cur     = stage_ack_i[k];
                w_en_cur      = stage_ack_en_i[k];
                w_idx_mask[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_idx    = r_idx;
        w_nxt_rstn   = r_rstn;
        w_nxt_busy   = r_busy;
        w_nxt_done   = r_done;
        w_nxt_fault  = r_fault;
        w_nxt_fstage = r_fstage;
        w_advance    = 1'b0;
        if (sw_rst_req_i) begin
            w_nxt_state  = S_HOLD;
            w_nxt_cnt    = '0;
            w_nxt_idx    = '0;
            w_nxt_rstn   = '0;
            w_nxt_busy   = 1'b1;
            w_nxt_done   = 1'b0;
            w_nxt_fault  = 1'b0;
            w_nxt_fstage = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        w_nxt_state = S_DELAY;
                        w_nxt_cnt   = '0;
                        w_nxt_idx   = '0;
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == C_DELAY_LAST) begin
                        w_nxt_rstn = r_rstn | w_idx_mask;
                        if (w_en_cur) begin
                            w_nxt_state = S_WAIT_ACK;
                            w_nxt_cnt   = '0;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack_cur) begin
                        w_advance = 1'b1;
                    end else if (r_cnt == C_TO_LAST) begin
                        w_nxt_state  = S_FAULT;
                        w_nxt_cnt    = '0;
                        w_nxt_rstn   = r_rstn & ~w_idx_mask;
                        w_nxt_fault  = 1'b1;
                        w_nxt_fstage = r_idx;
                        w_nxt_busy   = 1'b0;
                        w_nxt_done   = 1'b0;
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
                // done/busy flags follow one edge after the last stage's release
                S_DONE: begin
                    w_nxt_busy = 1'b0;
                    w_nxt_done = 1'b1;
                end
                S_FAULT: begin
                    w_nxt_state = S_FAULT;
                end
                default: begin
                    w_nxt_state = S_HOLD;
                    w_nxt_cnt   = '0;
                end
            endcase
            if (w_advance) begin
                w_nxt_cnt = '0;
                if (r_idx == C_LAST_IDX) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_DELAY;
                    w_nxt_idx   = r_idx + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state  <= S_HOLD;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rstn   <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_fstage <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_idx    <= w_nxt_idx;
            r_rstn   <= w_nxt_rstn;
            r_busy   <= w_nxt_busy;
            r_done   <= w_nxt_done;
            r_fault  <= w_nxt_fault;
            r_fstage <= w_nxt_fstage;
        end
    end

    assign stage_rstn_o  = r_rstn;
    assign seq_busy_o    = r_busy;
    assign seq_done_o    = r_done;
    assign fault_o       = r_fault;
    assign fault_stage_o = r_fstage;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for the orbit interlock gateware. It takes the single system clock and one global reset, and releases a set of downstream active-low reset domains one at a time, in order. Each release follows a programmable delay. For each stage the sequencer can optionally wait for a ready/lock acknowledge before moving on, with a timeout that raises a fault. It sits between the board clock/reset source and the interlock datapath blocks (ADC front-end, position calc, interlock logic, Wishbone).

Parameters:
G_NUM_STAGES, 4, number of sequenced reset domains (1..16)
G_HOLD_CYCLES, 16, cycles all stages stay asserted after sys_rst_i or a software request (>=1)
G_STAGE_DELAY, 8, cycles between entering a stage and releasing its reset (>=1)
G_ACK_TIMEOUT, 1024, maximum cycles to wait for a stage acknowledge (>=1)
G_CNT_WIDTH, 16, shared counter width; elaboration error if any of the three counts above exceeds 2**G_CNT_WIDTH-1

Ports:
clk_sys_i  in  1  system clock; the only clock
sys_rst_i  in  1  asynchronous, active-high reset
sw_rst_req_i  in  1  single-cycle software request to restart the sequence
stage_ack_i  in  G_NUM_STAGES  per-stage ready/lock level, already synchronous to clk_sys_i
stage_ack_en_i  in  G_NUM_STAGES  1 = wait for stage_ack_i[k] after releasing stage k; quasi-static
stage_rstn_o  out  G_NUM_STAGES  active-low resets to downstream domains, registered
seq_busy_o  out  1  sequence in progress
seq_done_o  out  1  all stages released
fault_o  out  1  acknowledge timeout occurred
fault_stage_o  out  4  index of the stage that timed out

Behaviour:
- Clock and reset: single clock clk_sys_i; asynchronous active-high reset sys_rst_i.
- All outputs are registered.
- Reset values while sys_rst_i=1: stage_rstn_o all 0; seq_busy_o=1; seq_done_o=0; fault_o=0; fault_stage_o=0; state HOLD; counter=0; idx=0.
- Timing reference: edge 1 is the first rising edge after sys_rst_i deasserts.
- HOLD: all stage_rstn_o=0 for exactly G_HOLD_CYCLES edges (edges 1..G_HOLD_CYCLES). Then go to DELAY with idx=0 and counter cleared.
- DELAY: lasts exactly G_STAGE_DELAY edges.
  - On its final edge, stage_rstn_o[idx] becomes 1 and stays 1.
  - Next state is WAIT_ACK if stage_ack_en_i[idx]=1, otherwise ADVANCE.
- WAIT_ACK: stage_ack_i[idx] is sampled every edge, starting the edge after the release.
  - Ack seen high -> ADVANCE on that edge.
  - G_ACK_TIMEOUT edges elapse without ack -> FAULT.
  - An ack already high at release therefore costs exactly 1 cycle.
- ADVANCE is folded into the same edge (no extra cycle):
  - idx<G_NUM_STAGES-1: idx+1, enter DELAY.
  - Last stage: enter DONE.
- DONE: seq_done_o=1, seq_busy_o=0. Ack drops are ignored. Stays in DONE until sw_rst_req_i or sys_rst_i.
- FAULT, on entry:
  - stage_rstn_o[idx] returns to 0; stages below idx stay released; stages above idx stay asserted.
  - fault_o=1, fault_stage_o=idx, seq_busy_o=0, seq_done_o=0.
  - Sticky; exits only via sw_rst_req_i or sys_rst_i.
- sw_rst_req_i=1 in any state, highest priority over every other transition on the same edge:
  - On that edge: all stage_rstn_o=0, seq_done_o=0, fault_o=0, fault_stage_o=0, seq_busy_o=1, idx=0, counter cleared, enter HOLD.
  - A request during HOLD restarts the hold count.
- sys_rst_i mid-sequence: immediate asynchronous return to the reset values.
- stage_rstn_o is monotonic within one sequence: a stage goes 0->1 at most once per sequence. Only FAULT, a software request or sys_rst_i can return it to 0.
- Release times with all acks disabled: stage k releases at edge G_HOLD_CYCLES+(k+1)*G_STAGE_DELAY; seq_done_o rises one edge after the last release.
- The counter saturates and never wraps; it is cleared on every state entry.

Test Plan:
- Defaults, stage_ack_en_i=0000, sys_rst_i pulse -> stage_rstn_o bits 0..3 rise at edges 24, 32, 40, 48; seq_done_o=1 and seq_busy_o=0 at edge 49; all outputs at reset values during the pulse.
- stage_ack_en_i=0010, stage_ack_i[1] raised 5 cycles after stage 1 release (edge 32) -> ack seen at edge 37; stage 2 releases at edge 45, stage 3 at edge 53; done at edge 54.
- stage_ack_en_i=0100, stage_ack_i[2] held 0 -> fault_o=1 and fault_stage_o=2 at edge 40+1024; stage_rstn_o=0011; busy=0, done=0; state held for 2000 more cycles.
- From that FAULT, pulse sw_rst_req_i, then raise stage_ack_i[2] -> next edge stage_rstn_o=0000 and fault_o=0; full sequence repeats from that edge; done asserts.
- sw_rst_req_i pulsed in DONE, and again at the same edge a stage ack arrives in WAIT_ACK -> software request wins both times; all stages 0; HOLD restarts for a full 16 cycles.
- sys_rst_i asserted asynchronously mid-DELAY (between edges) of stage 1 -> stage_rstn_o=0000 before the next edge; after release the sequence timing matches the first scenario exactly.
